// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU port controller.
package vdp_pkg;

  // Port select values on port_sel
  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  // Control-port second-byte command codes (cpu_din[7:6])
  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_REG   = 2'b10;

  // Display mode encodings
  localparam logic [2:0] MODE_TEXT  = 3'd0;
  localparam logic [2:0] MODE_GFX1  = 3'd1;
  localparam logic [2:0] MODE_GFX2  = 3'd2;
  localparam logic [2:0] MODE_MULTI = 3'd3;

  // Read-ahead engine states
  typedef enum logic [1:0] {
    RA_IDLE  = 2'd0,
    RA_FETCH = 2'd1,
    RA_CAP   = 2'd2
  } ra_state_t;

endpackage

// File: rtl/vdp_regfile.sv
// VDP register file R0..R(NUM_REGS-1) with combinational mode and table-base decode.
module vdp_regfile
  import vdp_pkg::*;
#(
  parameter int NUM_REGS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_we,
  input  logic [3:0]  reg_idx,
  input  logic [7:0]  reg_wdata,
  output logic [2:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic        video_on,
  output logic        vert_retrace_int,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic [7:0]  x_scroll,
  output logic [7:0]  y_scroll
);

  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] r [10];
  logic       unused_bits;

  // Register storage; indices at or above NUM_REGS match no entry and are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_idx == 4'(i)) regs_q[i] <= reg_wdata;
      end
    end
  end

  // Decode view of R0..R9; unimplemented registers read as zero
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      r[i] = '0;
      if (i < NUM_REGS) r[i] = regs_q[i];
    end
  end

  // Mode select: M1 (R1[4]) beats M3 (R0[1]) beats M2 (R1[3])
  always_comb begin
    mode = MODE_GFX1;
    if (r[1][4])      mode = MODE_TEXT;
    else if (r[0][1]) mode = MODE_GFX2;
    else if (r[1][3]) mode = MODE_MULTI;
  end

  // Table bases; graphics II uses only R3[7] for the color table
  always_comb begin
    name_table_addr           = {r[2][3:0], 10'b0};
    color_table_addr          = (mode == MODE_GFX2) ? {r[3][7], 13'b0} : {r[3], 6'b0};
    font_addr                 = {r[4][2:0], 11'b0};
    sprite_attr_addr          = {r[5][6:0], 7'b0};
    sprite_pattern_table_addr = {r[6][2:0], 11'b0};
  end

  assign video_on         = r[1][6];
  assign vert_retrace_int = r[1][5];
  assign sprite_large     = r[1][1];
  assign sprite_enlarged  = r[1][0];
  assign text_color       = r[7][7:4];
  assign back_color       = r[7][3:0];
  assign x_scroll         = r[8];
  assign y_scroll         = r[9];

  // Register bits with no decoded function
  assign unused_bits = ^{r[0][7:2], r[0][0], r[1][7], r[1][2], r[2][7:4],
                         r[4][7:3], r[5][7], r[6][7:3]};

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side port controller: control-port protocol, VRAM address/buffer,
// status flags and the VRAM read-ahead engine.
//
// state    | meaning
// ---------+--------------------------------------------------
// RA_IDLE  | no fetch pending
// RA_FETCH | vram_rd asserted at the current address
// RA_CAP   | capture vram_dout into the buffer, bump address
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int NUM_REGS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        port_sel,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_din,
  output logic        vram_wr,
  output logic        vram_rd,
  input  logic [7:0]  vram_dout,
  output logic [2:0]  mode,
  output logic [13:0] name_table_addr,
  output logic [13:0] color_table_addr,
  output logic [13:0] font_addr,
  output logic [13:0] sprite_attr_addr,
  output logic [13:0] sprite_pattern_table_addr,
  output logic        video_on,
  output logic        vert_retrace_int,
  output logic        sprite_large,
  output logic        sprite_enlarged,
  output logic [3:0]  text_color,
  output logic [3:0]  back_color,
  output logic [7:0]  x_scroll,
  output logic [7:0]  y_scroll,
  input  logic        interrupt_flag,
  input  logic        sprite_collision,
  input  logic        too_many_sprites,
  input  logic [4:0]  sprite5,
  output logic        n_int
);

  logic        first_q;
  logic [7:0]  latch_q;
  logic [13:0] addr_q;
  logic [7:0]  buf_q;
  logic        f_q, s5_q, c_q;
  logic [4:0]  fifth_q;
  logic        int_flag_d, too_many_d;
  logic        vram_wr_q;
  logic [13:0] wr_addr_q;
  logic [7:0]  wr_data_q;

  ra_state_t   state_q, state_d;
  logic        fetch_rd, cap_load;

  logic        data_wr, data_rd, ctrl_wr, stat_rd, ctrl_second;
  logic        reg_we, addr_load, ra_cmd, ra_trigger;
  logic        set_f, set_5s;

  assign data_wr     = cpu_wr & (port_sel == PORT_DATA);
  assign data_rd     = cpu_rd & (port_sel == PORT_DATA);
  assign ctrl_wr     = cpu_wr & (port_sel == PORT_CTRL);
  assign stat_rd     = cpu_rd & (port_sel == PORT_CTRL);
  assign ctrl_second = ctrl_wr & first_q;
  assign ra_trigger  = data_rd | ra_cmd;

  // Second control byte decode; code 11 behaves as a plain address set
  always_comb begin
    reg_we    = 1'b0;
    addr_load = 1'b0;
    ra_cmd    = 1'b0;
    if (ctrl_second) begin
      unique case (cpu_din[7:6])
        CMD_READ:  begin addr_load = 1'b1; ra_cmd = 1'b1; end
        CMD_WRITE: addr_load = 1'b1;
        CMD_REG:   reg_we = 1'b1;
        default:   addr_load = 1'b1;
      endcase
    end
  end

  vdp_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .reg_we                    (reg_we),
    .reg_idx                   (cpu_din[3:0]),
    .reg_wdata                 (latch_q),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .vert_retrace_int          (vert_retrace_int),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .text_color                (text_color),
    .back_color                (back_color),
    .x_scroll                  (x_scroll),
    .y_scroll                  (y_scroll)
  );

  // Read-ahead state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RA_IDLE;
    else          state_q <= state_d;
  end

  // Read-ahead next state; data writes abort, a new trigger restarts the fetch
  always_comb begin
    state_d  = state_q;
    fetch_rd = 1'b0;
    cap_load = 1'b0;
    case (state_q)
      RA_IDLE:  if (ra_trigger) state_d = RA_FETCH;
      RA_FETCH: begin fetch_rd = 1'b1; state_d = RA_CAP; end
      RA_CAP:   begin cap_load = 1'b1; state_d = RA_IDLE; end
      default:  state_d = RA_IDLE;
    endcase
    if (data_wr) begin
      state_d  = RA_IDLE;
      cap_load = 1'b0;
    end
    if (ra_trigger) begin
      state_d  = RA_FETCH;
      cap_load = 1'b0;
    end
  end

  // Control-port byte pairing, VRAM address and read buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q <= 1'b0;
      latch_q <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      if (ctrl_wr) begin
        if (!first_q) latch_q <= cpu_din;
        first_q <= ~first_q;
      end else if (data_wr | data_rd | stat_rd) begin
        first_q <= 1'b0;
      end
      if (addr_load)              addr_q <= {cpu_din[5:0], latch_q};
      else if (data_wr | cap_load) addr_q <= addr_q + 14'd1;
      if (data_wr)       buf_q <= cpu_din;
      else if (cap_load) buf_q <= vram_dout;
    end
  end

  // Registered VRAM write strobe with the pre-increment address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_wr_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      vram_wr_q <= data_wr;
      if (data_wr) begin
        wr_addr_q <= addr_q;
        wr_data_q <= cpu_din;
      end
    end
  end

  assign set_f  = interrupt_flag & ~int_flag_d;
  assign set_5s = too_many_sprites & ~too_many_d & ~s5_q;

  // Status flags; a set event in the same cycle as a status read wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q        <= 1'b0;
      s5_q       <= 1'b0;
      c_q        <= 1'b0;
      fifth_q    <= '0;
      int_flag_d <= 1'b0;
      too_many_d <= 1'b0;
    end else begin
      int_flag_d <= interrupt_flag;
      too_many_d <= too_many_sprites;
      f_q        <= set_f | (f_q & ~stat_rd);
      s5_q       <= set_5s | (s5_q & ~stat_rd);
      c_q        <= sprite_collision | (c_q & ~stat_rd);
      if (set_5s) fifth_q <= sprite5;
    end
  end

  assign cpu_dout  = (port_sel == PORT_CTRL) ? {f_q, s5_q, c_q, fifth_q} : buf_q;
  assign vram_wr   = vram_wr_q;
  assign vram_rd   = fetch_rd;
  assign vram_addr = vram_wr_q ? wr_addr_q : addr_q;
  assign vram_din  = wr_data_q;
  assign n_int     = ~(f_q & vert_retrace_int);

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port with a behavioural VRAM.
module tb_vdp_cpu_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        port_sel = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_dout;
  logic [13:0] vram_addr;
  logic [7:0]  vram_din;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_dout = '0;
  logic [2:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [3:0]  text_color, back_color;
  logic [7:0]  x_scroll, y_scroll;
  logic        interrupt_flag = 1'b0;
  logic        sprite_collision = 1'b0;
  logic        too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = '0;
  logic        n_int;

  always #5 clk = ~clk;

  vdp_cpu_port #(.NUM_REGS(10)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .port_sel                  (port_sel),
    .cpu_din                   (cpu_din),
    .cpu_wr                    (cpu_wr),
    .cpu_rd                    (cpu_rd),
    .cpu_dout                  (cpu_dout),
    .vram_addr                 (vram_addr),
    .vram_din                  (vram_din),
    .vram_wr                   (vram_wr),
    .vram_rd                   (vram_rd),
    .vram_dout                 (vram_dout),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .vert_retrace_int          (vert_retrace_int),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .text_color                (text_color),
    .back_color                (back_color),
    .x_scroll                  (x_scroll),
    .y_scroll                  (y_scroll),
    .interrupt_flag            (interrupt_flag),
    .sprite_collision          (sprite_collision),
    .too_many_sprites          (too_many_sprites),
    .sprite5                   (sprite5),
    .n_int                     (n_int)
  );

  // Behavioural VRAM: write on vram_wr, read data one cycle after vram_rd
  logic [7:0] vram_mem [16384];
  always @(posedge clk) begin
    if (vram_wr) vram_mem[vram_addr] <= vram_din;
    if (vram_rd) vram_dout <= vram_mem[vram_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [21:0] exp_w;
  logic [7:0]  exp_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes VRAM or the CPU reads
  always @(negedge clk) begin
    if (reset_n && vram_wr) begin
      if (exp_wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL vram write: unexpected addr %h data %h", vram_addr, vram_din);
      end else begin
        exp_w = exp_wr_q.pop_front();
        check("vram write {addr,data}", 32'({vram_addr, vram_din}), 32'(exp_w));
      end
    end
    if (reset_n && cpu_rd) begin
      if (exp_rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpu read: unexpected read data %h", cpu_dout);
      end else begin
        exp_r = exp_rd_q.pop_front();
        check("cpu read data", 32'(cpu_dout), 32'(exp_r));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe_wr(input logic sel, input logic [7:0] d);
    port_sel = sel; cpu_din = d; cpu_wr = 1'b1;
    idle(1);
    cpu_wr = 1'b0;
    idle(2);
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    strobe_wr(1'b1, d);
  endtask

  task automatic data_wr(input logic [13:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
    strobe_wr(1'b0, d);
  endtask

  task automatic rd(input logic sel, input logic [7:0] e);
    exp_rd_q.push_back(e);
    port_sel = sel; cpu_rd = 1'b1;
    idle(1);
    cpu_rd = 1'b0;
    idle(2);
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [7:0] v);
    ctrl_wr(v);
    ctrl_wr({4'h8, idx});
  endtask

  initial begin
    idle(3);
    check("reset n_int", 32'(n_int), 32'(1));
    check("reset vram_wr", 32'(vram_wr), 32'(0));
    check("reset vram_rd", 32'(vram_rd), 32'(0));
    reset_n = 1'b1;
    idle(1);
    check("reset mode", 32'(mode), 32'(1));
    check("reset name_table", 32'(name_table_addr), 32'(0));
    check("reset color_table", 32'(color_table_addr), 32'(0));
    check("reset x_scroll", 32'(x_scroll), 32'(0));
    rd(1'b1, 8'h00);

    // Register writes and decode
    set_reg(4'd2, 8'h00);
    check("name_table R2=00", 32'(name_table_addr), 32'(0));
    set_reg(4'd2, 8'h05);
    check("name_table R2=05", 32'(name_table_addr), 32'h1400);
    set_reg(4'd1, 8'h10);
    check("mode M1", 32'(mode), 32'(0));
    check("video_on R1=10", 32'(video_on), 32'(0));
    set_reg(4'd1, 8'h4B);
    check("mode M2", 32'(mode), 32'(3));
    check("video_on R1=4B", 32'(video_on), 32'(1));
    check("sprite size bits", 32'({sprite_large, sprite_enlarged}), 32'(3));
    set_reg(4'd3, 8'hFF);
    check("color_table mode3", 32'(color_table_addr), 32'h3FC0);
    set_reg(4'd0, 8'h02);
    check("mode M3 over M2", 32'(mode), 32'(2));
    check("color_table mode2", 32'(color_table_addr), 32'h2000);
    set_reg(4'd1, 8'h18);
    check("mode M1 over M3", 32'(mode), 32'(0));
    check("color_table mode0", 32'(color_table_addr), 32'h3FC0);
    set_reg(4'd0, 8'h00);
    set_reg(4'd4, 8'hFF);
    check("font_addr", 32'(font_addr), 32'h3800);
    set_reg(4'd5, 8'hFF);
    check("sprite_attr_addr", 32'(sprite_attr_addr), 32'h3F80);
    set_reg(4'd6, 8'h05);
    check("sprite_pattern_addr", 32'(sprite_pattern_table_addr), 32'h2800);
    set_reg(4'd7, 8'hF4);
    check("colors", 32'({text_color, back_color}), 32'hF4);
    set_reg(4'd8, 8'h12);
    set_reg(4'd9, 8'h34);
    check("scroll", 32'({x_scroll, y_scroll}), 32'h1234);

    // Sequential VRAM writes from 0x0000
    ctrl_wr(8'h00); ctrl_wr(8'h40);
    data_wr(14'h0000, 8'hAA);
    data_wr(14'h0001, 8'hBB);
    data_wr(14'h0002, 8'hCC);

    // Address wrap 3FFF -> 0000, then buffer and read-ahead
    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    data_wr(14'h3FFF, 8'h11);
    data_wr(14'h0000, 8'h22);
    rd(1'b0, 8'h22);
    rd(1'b0, 8'hBB);

    // Preload 0x1234/0x1235, then read back through the read-ahead
    ctrl_wr(8'h34); ctrl_wr(8'h52);
    data_wr(14'h1234, 8'h5A);
    data_wr(14'h1235, 8'hA5);
    ctrl_wr(8'h34); ctrl_wr(8'h12);
    idle(1);
    rd(1'b0, 8'h5A);
    rd(1'b0, 8'hA5);

    // Interrupt flag and n_int
    set_reg(4'd1, 8'h20);
    check("vert_retrace_int", 32'(vert_retrace_int), 32'(1));
    check("n_int before pulse", 32'(n_int), 32'(1));
    interrupt_flag = 1'b1;
    @(negedge clk);
    check("n_int in pulse cycle", 32'(n_int), 32'(1));
    @(posedge clk); #1;
    interrupt_flag = 1'b0;
    @(negedge clk);
    check("n_int after pulse", 32'(n_int), 32'(0));
    @(posedge clk); #1;
    idle(1);
    rd(1'b1, 8'h80);
    check("n_int after status read", 32'(n_int), 32'(1));

    interrupt_flag = 1'b1; idle(1); interrupt_flag = 1'b0; idle(2);
    check("n_int second pulse", 32'(n_int), 32'(0));
    exp_rd_q.push_back(8'h80);
    port_sel = 1'b1; cpu_rd = 1'b1; interrupt_flag = 1'b1;
    idle(1);
    cpu_rd = 1'b0; interrupt_flag = 1'b0;
    idle(2);
    check("n_int set wins over read", 32'(n_int), 32'(0));
    rd(1'b1, 8'h80);
    check("n_int after final read", 32'(n_int), 32'(1));

    // Fifth-sprite capture, hold while 5S set, collision flag
    sprite5 = 5'h13; too_many_sprites = 1'b1; idle(1);
    too_many_sprites = 1'b0; idle(1);
    sprite5 = 5'h07; too_many_sprites = 1'b1; idle(1);
    too_many_sprites = 1'b0; idle(1);
    rd(1'b1, 8'h53);
    rd(1'b1, 8'h13);
    sprite_collision = 1'b1; idle(1);
    sprite_collision = 1'b0; idle(1);
    rd(1'b1, 8'h33);
    rd(1'b1, 8'h13);

    // Status read resets the control-port byte pairing
    ctrl_wr(8'h34);
    rd(1'b1, 8'h13);
    ctrl_wr(8'h56); ctrl_wr(8'h40);
    data_wr(14'h0056, 8'h99);
    check("mode unchanged", 32'(mode), 32'(1));

    idle(4);
    check("vram write queue drained", 32'(exp_wr_q.size()), 32'(0));
    check("cpu read queue drained", 32'(exp_rd_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
